// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch
//   (read-only) and data access (read/write). Data has priority. A starvation
//   counter hands the grant to fetch after STARVE_LIMIT consecutive data
//   grants made while fetch was waiting.
//
//   Each access takes three cycles: IDLE (grant) -> ACCESS (address/write
//   strobe on the memory) -> RESP (capture read data, pulse ack). The ack
//   cycle is IDLE again, so the other port can be granted in that same cycle.
//
//   Optional build macro MEM_ARB_PERF_EN adds 16-bit saturating counters
//   perf_if_grants, perf_d_grants and perf_conflicts.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   if_req/if_addr   fetch request, held until if_ack
//   if_ack/if_rdata  one-cycle completion pulse, fetched byte (held)
//   d_req/d_we/d_addr/d_wdata   data request, held until d_ack
//   d_ack/d_rdata    one-cycle completion pulse, read byte (held)
//   mem_*            shared memory port; mem_read_data is registered
//   busy             high while in ACCESS or RESP
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_if_grants,
    output logic [15:0]       perf_d_grants,
    output logic [15:0]       perf_conflicts
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              win_if_q;          // 1 = current access belongs to fetch
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_ack_q, d_ack_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic if_elig, d_elig, grant, pick_if;

    // A request still held high during its own ack cycle must not win again.
    always_comb begin
        if_elig  = if_req & ~if_ack_q;
        d_elig   = d_req & ~d_ack_q;
        grant    = (state_q == IDLE) & (if_elig | d_elig);
        pick_if  = if_elig & (~d_elig | (starve_q == LIMIT));

        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ACCESS;
                    if (pick_if)     starve_d = 4'd0;
                    else if (if_elig) starve_d = starve_q + 4'd1;
                    else             starve_d = 4'd0;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            win_if_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (grant) begin
                win_if_q <= pick_if;
                we_q     <= ~pick_if & d_we;
                addr_q   <= pick_if ? if_addr : d_addr;
                if (!pick_if) wdata_q <= d_wdata;
            end
            if (state_q == RESP) begin
                if (win_if_q) begin
                    if_ack_q   <= 1'b1;
                    if_rdata_q <= mem_read_data;
                end else begin
                    d_ack_q <= 1'b1;
                    if (!we_q) d_rdata_q <= mem_read_data;
                end
            end
        end
    end

    // addr_q/wdata_q only change at a grant, so the memory bus holds its
    // last values outside ACCESS. The strobe is gated by rst so a reset
    // landing on an ACCESS cycle never commits the write.
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write_en   = (state_q == ACCESS) & we_q & ~rst;
    assign busy           = (state_q == ACCESS) | (state_q == RESP);
    assign if_ack         = if_ack_q;
    assign d_ack          = d_ack_q;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] pif_q, pd_q, pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pif_q <= '0;
            pd_q  <= '0;
            pc_q  <= '0;
        end else begin
            if (grant & pick_if & (pif_q != 16'hFFFF))  pif_q <= pif_q + 16'd1;
            if (grant & ~pick_if & (pd_q != 16'hFFFF))  pd_q  <= pd_q + 16'd1;
            if ((state_q == IDLE) & if_elig & d_elig & (pc_q != 16'hFFFF))
                pc_q <= pc_q + 16'd1;
        end
    end

    assign perf_if_grants = pif_q;
    assign perf_d_grants  = pd_q;
    assign perf_conflicts = pc_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed and random stimulus for mem_port_arbiter. A transaction-level
//   reference model (cycle numbers of grant/ack plus a shadow memory) predicts
//   every output each cycle; a simple synchronous memory sits on the mem port.
//   Build with MEM_ARB_PERF_EN defined to also check the perf counters.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic       if_ack, d_ack, mem_write_en, busy;
    logic [7:0] if_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Memory model with a backdoor load port used only while in reset.
    logic [7:0] mem [256];
    logic       bk_we = 1'b0;
    logic [7:0] bk_addr = '0, bk_data = '0;
    always @(posedge clk) begin
        if (bk_we)             mem[bk_addr] <= bk_data;
        else if (mem_write_en) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    // Requester protocol: while a request waits for its ack, nothing may move.
    logic       pv_ir = 1'b0, pv_ia = 1'b0, pv_dr = 1'b0, pv_da = 1'b0, pv_dwe = 1'b0;
    logic [7:0] pv_ia_addr = '0, pv_da_addr = '0, pv_dwd = '0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (pv_ir && !pv_ia)
                assert (if_req && if_addr == pv_ia_addr) else $error("protocol: fetch request moved before ack");
            if (pv_dr && !pv_da)
                assert (d_req && d_addr == pv_da_addr && d_we == pv_dwe && d_wdata == pv_dwd)
                else $error("protocol: data request moved before ack");
        end
        pv_ir <= if_req; pv_ia <= if_ack; pv_ia_addr <= if_addr;
        pv_dr <= d_req;  pv_da <= d_ack;  pv_da_addr <= d_addr;
        pv_dwe <= d_we;  pv_dwd <= d_wdata;
    end

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] ref_mem [256];
    int         cyc = 0, m_gnt = -10, m_ack = 0, m_starve = 0;
    int         m_pif = 0, m_pd = 0, m_pc = 0;
    logic       m_win_if = 1'b0, m_we = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0, e_ir = '0, e_dr = '0;

    // Requester state
    logic       if_act = 1'b0, d_act = 1'b0, if_fin = 1'b0, d_fin = 1'b0;
    logic       want_if = 1'b0, want_d = 1'b0, want_dwe = 1'b0;
    logic [7:0] want_if_addr = '0, want_d_addr = '0, want_dwd = '0;
    int         if_t0 = 0, d_t0 = 0, if_lat = 0, d_lat = 0, if_wmax = 0;

    task automatic model_reset();
        m_gnt = -10; m_ack = 0; m_starve = 0; m_win_if = 1'b0; m_we = 1'b0;
        e_ir = '0; e_dr = '0; m_pif = 0; m_pd = 0; m_pc = 0;
        if_act = 1'b0; d_act = 1'b0; if_fin = 1'b0; d_fin = 1'b0;
        want_if = 1'b0; want_d = 1'b0;
    endtask

    task automatic chk_perf(input string tag, input int pif, input int pd, input int pc);
`ifdef MEM_ARB_PERF_EN
        chk({tag, "_perf_if"}, 32'(perf_if_grants), 32'(pif));
        chk({tag, "_perf_d"},  32'(perf_d_grants),  32'(pd));
        chk({tag, "_perf_cf"}, 32'(perf_conflicts), 32'(pc));
`else
        if (pif < 0 || pd < 0 || pc < 0) $display("note: %s negative model count", tag);
`endif
    endtask

    // Reset for n cycles starting in the next cycle; outstanding requests drop.
    task automatic do_reset(input int n);
        @(posedge clk); #1; cyc++;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        #1 chk("rst_we_gated", 32'(mem_write_en), 32'd0);
        repeat (n) begin @(posedge clk); #1; cyc++; end
        chk("rst_if_ack",  32'(if_ack), 32'd0);
        chk("rst_d_ack",   32'(d_ack), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        chk("rst_mem_wd",  32'(mem_write_data), 32'd0);
        chk("rst_mem_we",  32'(mem_write_en), 32'd0);
        chk_perf("rst", 0, 0, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: check outputs against the model, drive requesters,
    // then let the model arbitrate on the inputs of this cycle.
    task automatic step(input int p_if, input int p_d);
        logic e_ia, e_da, ie, de, pick;
        @(posedge clk); #1; cyc++;
        e_ia = (cyc == m_ack) && m_win_if;
        e_da = (cyc == m_ack) && !m_win_if;
        if (e_ia) e_ir = m_rdata;
        if (e_da && !m_we) e_dr = m_rdata;
        if (cyc == m_gnt + 1 && m_we) ref_mem[m_addr] = m_wdata;
        chk("if_ack", 32'(if_ack), 32'(e_ia));
        chk("d_ack", 32'(d_ack), 32'(e_da));
        chk("if_rdata", 32'(if_rdata), 32'(e_ir));
        chk("d_rdata", 32'(d_rdata), 32'(e_dr));
        chk("busy", 32'(busy), 32'(cyc == m_gnt + 1 || cyc == m_gnt + 2));
        chk("mem_we", 32'(mem_write_en), 32'(cyc == m_gnt + 1 && m_we));
        if (cyc == m_gnt + 1) begin
            chk("mem_addr", 32'(mem_address), 32'(m_addr));
            if (m_we) chk("mem_wdata", 32'(mem_write_data), 32'(m_wdata));
        end

        if (if_fin) begin if_req = 1'b0; if_act = 1'b0; if_fin = 1'b0; end
        if (d_fin)  begin d_req = 1'b0;  d_act = 1'b0;  d_fin = 1'b0;  end
        if (if_ack) begin
            if_fin = 1'b1; if_lat = cyc - if_t0;
            if (if_lat > if_wmax) if_wmax = if_lat;
        end
        if (d_ack) begin d_fin = 1'b1; d_lat = cyc - d_t0; end
        if (!if_act && (want_if || $urandom_range(99) < p_if)) begin
            if_act = 1'b1; if_req = 1'b1; if_t0 = cyc;
            if_addr = want_if ? want_if_addr : 8'($urandom);
            want_if = 1'b0;
        end
        if (!d_act && (want_d || $urandom_range(99) < p_d)) begin
            d_act = 1'b1; d_req = 1'b1; d_t0 = cyc;
            d_addr  = want_d ? want_d_addr : 8'($urandom);
            d_we    = want_d ? want_dwe    : 1'($urandom);
            d_wdata = want_d ? want_dwd    : 8'($urandom);
            want_d = 1'b0;
        end

        if (cyc >= m_ack) begin
            ie = if_req && !e_ia;
            de = d_req && !e_da;
            if (ie || de) begin
                pick = ie && (!de || m_starve == LIM);
                if (ie && de) m_pc++;
                if (pick) begin m_starve = 0; m_pif++; end
                else begin m_starve = ie ? m_starve + 1 : 0; m_pd++; end
                m_gnt = cyc; m_ack = cyc + 3; m_win_if = pick;
                m_we = !pick && d_we;
                m_addr = pick ? if_addr : d_addr;
                m_wdata = d_wdata;
                if (!m_we) m_rdata = ref_mem[m_addr];
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!(!if_act && !d_act && !want_if && !want_d && cyc >= m_ack) && n < 60) begin
            step(0, 0); n++;
        end
        chk("drain_timeout", 32'(n < 60), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hA5;
        ref_mem[8'h30] = 8'h11;
        for (int i = 0; i < 256; i++) begin
            bk_we = 1'b1; bk_addr = 8'(i); bk_data = ref_mem[i];
            @(posedge clk); #1;
        end
        bk_we = 1'b0;
        do_reset(3);

        // Single fetch of 0x10
        want_if = 1'b1; want_if_addr = 8'h10;
        drain();
        chk("fetch_lat", 32'(if_lat), 32'd3);
        chk("fetch_data", 32'(if_rdata), 32'hA5);

        // Data write 0x3C to 0x20, then read back
        want_d = 1'b1; want_d_addr = 8'h20; want_dwe = 1'b1; want_dwd = 8'h3C;
        drain();
        chk("wr_lat", 32'(d_lat), 32'd3);
        want_d = 1'b1; want_d_addr = 8'h20; want_dwe = 1'b0; want_dwd = 8'h00;
        drain();
        chk("rd_lat", 32'(d_lat), 32'd3);
        chk("rd_data", 32'(d_rdata), 32'h3C);

        // Simultaneous requests: data first, fetch granted in the data ack cycle
        do_reset(1);
        want_if = 1'b1; want_if_addr = 8'h40;
        want_d = 1'b1; want_d_addr = 8'h41; want_dwe = 1'b0;
        drain();
        chk("sim_d_lat", 32'(d_lat), 32'd3);
        chk("sim_if_lat", 32'(if_lat), 32'd6);
        chk_perf("sim", 1, 1, 1);

        // Reset lands on the ACCESS cycle of a write to 0x30
        want_d = 1'b1; want_d_addr = 8'h30; want_dwe = 1'b1; want_dwd = 8'h99;
        step(0, 0);
        do_reset(1);
        chk("midwr_mem", 32'(mem[8'h30]), 32'h11);
        repeat (5) step(0, 0);
        want_d = 1'b1; want_d_addr = 8'h30; want_dwe = 1'b0;
        drain();
        chk("midwr_readback", 32'(d_rdata), 32'h11);

        // Random traffic
        repeat (300) step(30, 30);
        drain();
        if_wmax = 0;
        repeat (90) step(100, 100);
        drain();
        chk("if_wait_bound", 32'(if_wmax <= 3 * (LIM + 1) + 3), 32'd1);
        repeat (200) step(70, 20);
        drain();
        chk_perf("rand", m_pif, m_pd, m_pc);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous memory between two requesters: instruction fetch (read-only) and data access (read/write).
- Sits between the program-counter/fetch path, the data-access path and the shared memory.
- Enables a single-port memory build of the 8-bit CPU instead of separate instruction and data memories.
- Fixed data-over-fetch priority, with a starvation guard that bounds how long fetch can be held off.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- clk  input  1  system clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse; if_rdata is valid.
- if_rdata  output  DATA_W  fetched byte; held until the next if_ack.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_ack  output  1  one-cycle pulse on completion of a read or write.
- d_rdata  output  DATA_W  read byte; held until the next d_ack for a read.
- mem_address  output  ADDR_W  shared memory address.
- mem_write_en  output  1  shared memory write strobe.
- mem_write_data  output  DATA_W  shared memory write data.
- mem_read_data  input  DATA_W  registered memory read data, valid one cycle after the address.
- busy  output  1  high in the ACCESS and RESP states.

Behaviour:
- The memory is synchronous:
  - write commits at the edge ending the cycle in which mem_write_en is high;
  - read data appears the cycle after mem_address is presented.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The arbiter evaluates the eligible requests.
  - A port is eligible when its req is high and its ack is not high in the same cycle; this masks the request still held during the ack cycle.
  - If any port is eligible: latch the winner, its address, we and wdata (we is 0 for fetch), then go to ACCESS.
- ACCESS:
  - mem_address is driven from the latched address.
  - mem_write_en = latched we.
  - mem_write_data = latched wdata.
  - Next state is RESP.
- RESP:
  - Register mem_read_data into the winner's rdata; a data write leaves d_rdata unchanged.
  - Set the winner's ack register, then go to IDLE.
- Latency:
  - req sampled in IDLE at cycle T → ack high at T+3.
  - Throughput is one access per 3 cycles.
  - A new grant is possible in the ack cycle itself, for the other port only.
- Outside ACCESS: mem_write_en = 0; mem_address and mem_write_data hold their last values.
- Arbitration:
  - Data wins by default.
  - starve_cnt increments on each data grant made while fetch is also eligible.
  - starve_cnt clears on a fetch grant, or on a data grant made while fetch is not eligible.
  - When starve_cnt == STARVE_LIMIT and both ports are eligible, fetch wins.
  - starve_cnt never exceeds STARVE_LIMIT.
- Reset (rst high):
  - State goes to IDLE; starve_cnt = 0.
  - if_ack, d_ack, busy = 0.
  - if_rdata, d_rdata, mem_address, mem_write_data = 0.
  - mem_write_en is gated combinationally with ~rst, so a write caught in ACCESS is not committed.
  - Any outstanding transaction is dropped and no ack is issued.
- Protocol violations (changing addr/we/wdata, or dropping req before ack) are undefined for the RTL. The bench flags them with assertions.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds three outputs, each a 16-bit saturating counter cleared by rst:
  - perf_if_grants: count of fetch grants.
  - perf_d_grants: count of data grants.
  - perf_conflicts: count of IDLE cycles where both ports are eligible.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single fetch:
  - Stimulus: memory[0x10]=0xA5; if_req with if_addr=0x10 at cycle 5.
  - Response: mem_address=0x10 in cycle 6; busy in cycles 6–7; if_ack in cycle 8 with if_rdata=0xA5; mem_write_en never high.
- Data write then read:
  - Stimulus: d_we=1, d_addr=0x20, d_wdata=0x3C at T; then a read of 0x20.
  - Response: mem_write_en high in T+1 only; d_ack at T+3. The read returns d_ack at its own T'+3 with d_rdata=0x3C.
- Simultaneous requests at T:
  - Response: data granted first, d_ack at T+3.
  - Fetch is granted in cycle T+3 while d_req is masked; if_ack at T+6.
- Starvation guard:
  - Stimulus: STARVE_LIMIT=4; d_req re-asserted every transaction; if_req held.
  - Response: grants run data ×4 then fetch; starve_cnt returns to 0; the pattern repeats.
- Reset mid-write:
  - Stimulus: rst high during the ACCESS cycle of a write to 0x30 (old value 0x11).
  - Response: mem_write_en=0; memory[0x30] stays 0x11; no d_ack; all outputs 0 the next cycle.
- Performance counters (MEM_ARB_PERF_EN defined):
  - Stimulus: run the simultaneous-request scenario.
  - Response: perf_conflicts=1, perf_d_grants=1, perf_if_grants=1. After rst, all counters are 0.
